// File: rtl/pipe_delay.sv
// Delay line: WIDTH-bit word plus valid bit through DEPTH enabled register stages,
// with a global stall enable, a synchronous flush and a count of valid words in flight.
module pipe_delay #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter bit               GATE_DATA = 1'b0,
  localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] q_o,
  output logic [OCC_W-1:0] occ_o
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
    $error("pipe_delay: DEPTH and WIDTH must both be >= 1");
  end

  // valid_i qualifies d_i on an enabled edge; there is no ready: the line never
  // back-pressures, and a word leaving the last stage is gone after the edge
  // that moves it out, so the consumer samples valid_o/q_o on every enabled edge.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (flush_i) begin
      valid_d = '0;
      occ_d   = '0;
      for (int k = 0; k < DEPTH; k++) data_d[k] = RST_VAL;
    end else if (en_i) begin
      valid_d[0] = valid_i;
      if (!GATE_DATA || valid_i) data_d[0] = d_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        // Gated mode: a bubble moving in leaves the stage's old data in place
        if (!GATE_DATA || valid_q[k-1]) data_d[k] = data_q[k-1];
      end
      occ_d = occ_q + OCC_W'(valid_i) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign q_o     = data_q[DEPTH-1];
  assign occ_o   = occ_q;

endmodule

// File: tb/tb_pipe_delay.sv
// Bench for pipe_delay: four configurations driven in parallel, checked against a
// history-of-accepted-inputs model plus directed constant expectations.
module tb_pipe_delay;

  localparam logic [7:0] RV = 8'hA5;
  localparam int DEP [4] = '{4, 4, 1, 7};
  localparam bit GAT [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  logic       clk;
  logic       reset;
  logic       en_i, flush_i, valid_i;
  logic [7:0] d_i;

  logic       v0, v1, v2, v3;
  logic [7:0] q0, q1, q2, q3;
  logic [2:0] o0, o1, o3;
  logic [0:0] o2;

  logic       vo  [4];
  logic [7:0] qo  [4];
  logic [2:0] occo[4];

  always_comb begin
    vo[0] = v0; vo[1] = v1; vo[2] = v2; vo[3] = v3;
    qo[0] = q0; qo[1] = q1; qo[2] = q2; qo[3] = q3;
    occo[0] = o0; occo[1] = o1; occo[2] = {2'b00, o2}; occo[3] = o3;
  end

  pipe_delay #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .GATE_DATA(1'b0)) u_d4g0 (
    .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
    .d_i(d_i), .valid_o(v0), .q_o(q0), .occ_o(o0));
  pipe_delay #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .GATE_DATA(1'b1)) u_d4g1 (
    .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
    .d_i(d_i), .valid_o(v1), .q_o(q1), .occ_o(o1));
  pipe_delay #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV), .GATE_DATA(1'b0)) u_d1g0 (
    .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
    .d_i(d_i), .valid_o(v2), .q_o(q2), .occ_o(o2));
  pipe_delay #(.WIDTH(8), .DEPTH(7), .RST_VAL(RV), .GATE_DATA(1'b1)) u_d7g1 (
    .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
    .d_i(d_i), .valid_o(v3), .q_o(q3), .occ_o(o3));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: inputs accepted since the last flush/reset, newest at the back
  ent_t       hist [4][$];
  logic [7:0] last_exit [4];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      last_exit[i] = RV;
    end
  endtask

  task automatic model_edge(input bit en, input bit fl, input bit v, input logic [7:0] d);
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      if (fl) begin
        hist[i].delete();
        last_exit[i] = RV;
      end else if (en) begin
        e.v = v;
        e.d = d;
        hist[i].push_back(e);
        if (hist[i].size() > DEP[i]) begin
          e = hist[i].pop_front();
          if (e.v) last_exit[i] = e.d;
        end
      end
    end
  endtask

  // scoreboard: compare all four instances with the model
  task automatic check_all(input string tag);
    bit         full, ev;
    logic [7:0] eq;
    int         eo;
    for (int i = 0; i < 4; i++) begin
      full = (hist[i].size() == DEP[i]);
      ev   = full && hist[i][0].v;
      if (GAT[i]) eq = ev ? hist[i][0].d : last_exit[i];
      else        eq = full ? hist[i][0].d : RV;
      eo = 0;
      foreach (hist[i][j]) if (hist[i][j].v) eo++;
      chk($sformatf("%s u%0d valid", tag, i), 32'(vo[i]), 32'(ev));
      chk($sformatf("%s u%0d q", tag, i), 32'(qo[i]), 32'(eq));
      chk($sformatf("%s u%0d occ", tag, i), 32'(occo[i]), 32'(eo));
      chk($sformatf("%s u%0d occ_le_depth", tag, i), 32'(occo[i] <= 3'(DEP[i])), 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s u%0d valid", tag, i), 32'(vo[i]), 32'd0);
      chk($sformatf("%s u%0d q", tag, i), 32'(qo[i]), 32'(RV));
      chk($sformatf("%s u%0d occ", tag, i), 32'(occo[i]), 32'd0);
    end
  endtask

  // driver: one clock cycle, optional asynchronous reset pulse in the low phase
  task automatic step(input bit en, input bit fl, input bit v, input logic [7:0] d,
                      input bit rst_pulse, input string tag);
    @(negedge clk);
    en_i = en; flush_i = fl; valid_i = v; d_i = d;
    if (rst_pulse) begin
      #1 reset = 1'b0;
      #1 check_reset_vals({tag, " async_rst"});
      model_clear();
      #1 reset = 1'b1;
    end
    @(posedge clk);
    model_edge(en, fl, v, d);
    #1 check_all(tag);
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = '0;
    model_clear();
    #2 reset = 1'b0;
    #1 check_reset_vals("reset_immediate");
    @(negedge clk);
    reset = 1'b1;

    // streaming 1..5
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 8'(k), 1'b0, "stream");
      chk("stream occ const", 32'(o0), 32'(k < 4 ? k : 4));
      if (k >= 4) begin
        chk("stream q const", 32'(q0), 32'(k - 3));
        chk("stream valid const", 32'(v0), 32'd1);
      end
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "drain");

    // stall
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "stall_flush");
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, "stall_load");
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, "stall_load");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, "stall_hold");
      chk("stall occ const", 32'(o0), 32'd2);
      chk("stall valid const", 32'(v0), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall_resume");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall_resume");
    chk("stall first out const", 32'(q0), 32'h11);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall_resume");
    chk("stall second out const", 32'(q0), 32'h22);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall_resume");
    chk("stall no dup const", 32'(v0), 32'd0);

    // flush priority
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0, "fl_load");
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, "fl_flush");
    chk("flush occ const", 32'(o0), 32'd0);
    chk("flush valid const", 32'(v0), 32'd0);
    chk("flush q const", 32'(q0), 32'hA5);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "fl_after");
      chk("flush no FF const", 32'(q3 == 8'hFF || q0 == 8'hFF), 32'd0);
    end

    // bubbles
    step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, "bub");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "bub");
    chk("bub gated q const", 32'(q1), 32'h3C);
    chk("bub gated valid const", 32'(v1), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "bub");
    chk("bub gated hold q const", 32'(q1), 32'h3C);
    chk("bub gated hold valid const", 32'(v1), 32'd0);
    chk("bub ungated q const", 32'(q0), 32'h00);

    // random soak with async reset pulses
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0),
           1'($urandom_range(1, 0)), 8'($urandom), ($urandom_range(39, 0) == 0), "soak");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_delay.md
# pipe_delay

Parametrised delay line: registers a WIDTH-bit data word plus a valid bit through DEPTH flop stages, with a global stall enable, a synchronous flush and a running count of valid entries in flight. It is the generalised successor to the team's single-bit flop primitives and is used wherever a datapath must be delay-matched to a multi-cycle control path. Async reset and sync flush coexist; flush has priority over enable.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages = latency in enabled cycles (>= 1)
- RST_VAL, '0, WIDTH-bit value loaded into every data stage on reset or flush
- GATE_DATA, 0, 1 = a stage's data register loads only when the incoming valid bit is 1 (bubbles hold old data); 0 = data always shifts
- Parameter checks: DEPTH < 1 or WIDTH < 1 is a elaboration error.

- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- en_i  input  1  advance pipeline this cycle; 0 = all stages hold
- flush_i  input  1  synchronous clear of all stages
- valid_i  input  1  d_i carries a valid word
- d_i  input  WIDTH  input data
- valid_o  output  1  valid bit of last stage
- q_o  output  WIDTH  data of last stage
- occ_o  output  $clog2(DEPTH+1)  number of stages whose valid bit is 1

## Operation
- State: DEPTH stages, each {valid[k], data[k]}; stage 0 is input side, stage DEPTH-1 drives valid_o/q_o.
- Priority per rising clk edge (reset asserted overrides all, asynchronously):
  - reset low: all valid[k]=0, all data[k]=RST_VAL, occ=0, immediately, no clock needed.
  - flush_i=1: all valid[k]=0, data[k]=RST_VAL, occ=0; en_i, valid_i, d_i ignored this cycle (input word dropped).
  - en_i=1: valid[0]<=valid_i; valid[k]<=valid[k-1]. Data: GATE_DATA=0 -> data[0]<=d_i, data[k]<=data[k-1]; GATE_DATA=1 -> data[0] loads d_i only if valid_i, data[k] loads data[k-1] only if valid[k-1], otherwise holds.
  - en_i=0: every register holds.
- Occupancy: incremental counter, not a popcount. On en_i=1 and no flush: occ <= occ + valid_i - valid[DEPTH-1]. Simultaneous entry and exit -> unchanged. Invariant 0 <= occ_o <= DEPTH; occ_o always equals popcount(valid[]).
- Words leaving the last stage are not held; downstream must sample valid_o/q_o on the same edge en_i advances.
- DEPTH=1 is a single enabled, flushable register with occ_o in {0,1}.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Latency: word accepted at edge N (en_i=1, valid_i=1) appears on valid_o/q_o after the DEPTH-th enabled edge, counting edge N as the first; with en_i held 1, visible DEPTH cycles after presentation.
- Stall cycles (en_i=0) add exactly one cycle each to latency of every in-flight word; order preserved, no loss, no duplication.
- Flush takes effect at the edge it is sampled; outputs read valid_o=0, q_o=RST_VAL, occ_o=0 the following cycle.
- Reset deassertion is asynchronous in the RTL; system synchronises release. First capture at first rising edge with reset high.
- Reset values: valid_o=0, q_o=RST_VAL, occ_o=0.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RST_VAL=8'hA5; drive reset low mid-cycle with no clk edge -> valid_o=0, q_o=8'hA5, occ_o=0 immediately.
- Streaming: en_i=1, valid_i=1, d_i=1,2,3,4,5 on consecutive cycles -> q_o=1..5 with valid_o=1 starting 4 cycles after d_i=1; occ_o ramps 1,2,3,4 then stays 4.
- Stall: load 8'h11, 8'h22; hold en_i=0 for 3 cycles -> outputs and occ_o=2 frozen; resume en_i=1 -> 8'h11 then 8'h22 emerge, each 3 cycles later than unstalled, no duplicates.
- Flush priority: pipeline holds 3 valid words, assert flush_i=1 with en_i=1, valid_i=1, d_i=8'hFF -> next cycle occ_o=0, valid_o=0, q_o=8'hA5; 8'hFF never appears at output.
- Bubbles, GATE_DATA=1: send 8'h3C valid then 3 bubbles (valid_i=0, d_i=8'h00) -> q_o=8'h3C with valid_o=1 for one cycle, then valid_o=0 while q_o stays 8'h3C; with GATE_DATA=0, q_o becomes 8'h00.
- Random soak, DEPTH=1 and DEPTH=7: random en_i/flush_i/valid_i and async reset pulses mid-stream -> scoreboard matches order and latency; occ_o always equals popcount of valid stages and never exceeds DEPTH.
